// File: rtl/seq_10x1_pkg.sv
// seq_10x1_pkg: shared state encoding and frame pattern for the 10X1 sequence link
package seq_10x1_pkg;
  typedef enum logic [2:0] {IDLE, B1, B0, BX, BL, GAP} state_e;
  localparam int FRAME_LEN = 4;
  localparam logic [1:0] PAT_HEAD = 2'b10;
  localparam logic PAT_TAIL = 1'b1;
endpackage

// File: rtl/seq_10x1_down_cnt.sv
// seq_10x1_down_cnt: loadable saturating down-counter
//   clk, reset(async, high) | load, load_val -> cnt | dec: cnt-1, holds at 0 | zero: cnt==0
module seq_10x1_down_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/seq_gen_10x1.sv
// seq_gen_10x1: serial transmitter of bursts of "1,0,X,1" frames, each followed by GAP_LEN zeros
//   clk, reset(async, high)
//   in_valid/in_ready/in_xbit/in_count: burst request handshake, sampled only at acceptance
//   abort: cancels a running burst without done pulses
//   x/x_valid: serial bit and frame-bit qualifier; frame_done: last '1' of a frame; burst_done: first idle cycle after a burst
module seq_gen_10x1 #(
  parameter int CNT_W   = 8,
  parameter int GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_xbit,
  input  logic [CNT_W-1:0] in_count,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             frame_done,
  output logic             burst_done
);
  import seq_10x1_pkg::*;
  localparam int GW = GAP_LEN > 0 ? $clog2(GAP_LEN + 1) : 1;
  state_e state_q, state_d;
  logic xbit_q, xbit_d;
  logic x_q, x_d, x_valid_q, x_valid_d, frame_done_q, frame_done_d;
  logic burst_done_q, burst_done_d, in_ready_q, in_ready_d;
  logic accept, frames_zero, frames_last, gap_zero;
  logic [CNT_W-1:0] frames_cnt;
  assign accept = (state_q == IDLE) && in_valid;
  assign frames_last = (frames_cnt == CNT_W'(1));
  seq_10x1_down_cnt #(.W(CNT_W)) u_frames (
    .clk(clk), .reset(reset), .load(accept), .load_val(in_count),
    .dec(state_q == BL), .cnt(frames_cnt), .zero(frames_zero)
  );
  generate
    if (GAP_LEN > 0) begin : g_gap
      logic [GW-1:0] unused_gap_cnt;
      // loaded with GAP_LEN-1 so zero marks the final gap cycle
      seq_10x1_down_cnt #(.W(GW)) u_gap (
        .clk(clk), .reset(reset), .load(state_q == BL), .load_val(GW'(GAP_LEN - 1)),
        .dec(state_q == GAP), .cnt(unused_gap_cnt), .zero(gap_zero)
      );
    end else begin : g_no_gap
      assign gap_zero = 1'b1;
    end
  endgenerate
  always_comb begin
    state_d = state_q;
    xbit_d = xbit_q;
    case (state_q)
      IDLE: if (accept) begin
        xbit_d = in_xbit;
        state_d = (in_count != '0) ? B1 : IDLE;
      end
      B1: state_d = B0;
      B0: state_d = BX;
      BX: state_d = BL;
      // frames_cnt is decremented in BL, so BL tests "last" and GAP tests "zero"
      BL: state_d = (GAP_LEN > 0) ? GAP : frames_last ? IDLE : B1;
      GAP: state_d = !gap_zero ? GAP : frames_zero ? IDLE : B1;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    x_d = (state_d == B1) ? PAT_HEAD[1] : (state_d == B0) ? PAT_HEAD[0] :
          (state_d == BX) ? xbit_d : (state_d == BL) ? PAT_TAIL : 1'b0;
    x_valid_d = (state_d == B1) || (state_d == B0) || (state_d == BX) || (state_d == BL);
    frame_done_d = (state_d == BL);
    in_ready_d = (state_d == IDLE);
    // empty burst, or natural end of a burst that was not aborted
    burst_done_d = (state_d == IDLE) && (accept || (state_q != IDLE && !abort));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      xbit_q <= 1'b0;
      x_q <= 1'b0;
      x_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      burst_done_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      xbit_q <= xbit_d;
      x_q <= x_d;
      x_valid_q <= x_valid_d;
      frame_done_q <= frame_done_d;
      burst_done_q <= burst_done_d;
      in_ready_q <= in_ready_d;
    end
  assign x = x_q;
  assign x_valid = x_valid_q;
  assign frame_done = frame_done_q;
  assign burst_done = burst_done_q;
  assign in_ready = in_ready_q;
endmodule

// File: tb/tb_seq_gen_10x1.sv
// tb_seq_gen_10x1: random and directed bursts on GAP_LEN=2 and GAP_LEN=0 instances against a frame-list model
module tb_seq_gen_10x1;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_xbit = 0, abort = 0;
  logic [7:0] in_count = 0;
  logic [1:0] rdy, x, xv, fd, bd;
  localparam logic [4:0] IDLE_V = 5'b00001;
  logic [4:0] q [2][$];
  logic [4:0] cur [2];
  logic [4:0] nxt [2];
  int checks = 0, failures = 0, cyc = 0;
  always #5 clk = ~clk;
  seq_gen_10x1 #(.CNT_W(8), .GAP_LEN(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_xbit(in_xbit),
    .in_count(in_count), .abort(abort), .x(x[0]), .x_valid(xv[0]), .frame_done(fd[0]), .burst_done(bd[0])
  );
  seq_gen_10x1 #(.CNT_W(8), .GAP_LEN(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_xbit(in_xbit),
    .in_count(in_count), .abort(abort), .x(x[1]), .x_valid(xv[1]), .frame_done(fd[1]), .burst_done(bd[1])
  );
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got{x,xv,fd,bd,rdy}=%b exp=%b", tag, cyc, got, exp);
    end
  endtask
  // whole burst as a list of per-cycle output vectors {x,x_valid,frame_done,burst_done,in_ready}
  task automatic build(input int d, input logic xb, input int cnt);
    int gap = (d == 0) ? 2 : 0;
    for (int f = 0; f < cnt; f++) begin
      q[d].push_back(5'b11000);
      q[d].push_back(5'b01000);
      q[d].push_back({xb, 4'b1000});
      q[d].push_back(5'b11100);
      for (int g = 0; g < gap; g++) q[d].push_back(5'b00000);
    end
    q[d].push_back(5'b00011);
  endtask
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      if (cur[d][0] && in_valid) begin
        q[d].delete();
        build(d, in_xbit, int'(in_count));
      end else if (!cur[d][0] && abort) q[d].delete();
      nxt[d] = (q[d].size() != 0) ? q[d].pop_front() : IDLE_V;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      check(d == 0 ? "gap2" : "gap0", {x[d], xv[d], fd[d], bd[d], rdy[d]}, nxt[d]);
      cur[d] = nxt[d];
    end
    @(negedge clk);
  endtask
  task automatic request(input logic xb, input int cnt, input int idle);
    in_valid = 1; in_xbit = xb; in_count = 8'(cnt);
    step();
    in_valid = 0; in_xbit = $urandom; in_count = 8'($urandom);
    repeat (idle) step();
  endtask
  task automatic async_reset();
    #2 reset = 1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_async", {x[d], xv[d], fd[d], bd[d], rdy[d]}, IDLE_V);
      q[d].delete();
      cur[d] = IDLE_V;
    end
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    cur[0] = IDLE_V; cur[1] = IDLE_V;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) check("reset", {x[d], xv[d], fd[d], bd[d], rdy[d]}, IDLE_V);
    @(negedge clk);
    reset = 0;
    request(0, 1, 9);
    request(1, 3, 20);
    request(0, 0, 3);
    request(1, 5, 6);
    abort = 1; step(); abort = 0;
    request(0, 2, 14);
    request(1, 3, 2);
    async_reset();
    repeat (4) step();
    request(1, 255, 1540);
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 9) < 3);
      in_xbit = $urandom;
      in_count = 8'($urandom_range(0, 4));
      abort = ($urandom_range(0, 99) < 3);
      step();
      if (i % 700 == 699) async_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
